// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_W        - register-index width
//   WAIT_W       - width of the memory wait counter (covers timeouts up to 1023)
//   fwd_sel_e    - EX operand source encodings
//   mem_state_e  - data-memory wait FSM states
//   fwd_hit()    - one forwarding-match test (write enable, matching index, non-zero source)
package pipe_hazard_ctrl_pkg;

    localparam int REG_W  = 5;
    localparam int WAIT_W = 10;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // x0 is hard-wired to zero, so a zero source never takes a forwarded value.
    function automatic logic fwd_hit(input logic             we,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src);
        return we && (rd == src) && (src != {REG_W{1'b0}});
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Interface bundling the datapath-facing hazard signals.
//   master : the datapath (drives stage information, receives controls)
//   slave  : the hazard controller
// Inputs to the controller: ID/EX/MEM/WB register indices and enables, branch
// resolution, memory request/ack. Outputs: stage stall/flush/bubble controls,
// forwarding selects, memory abort/error pulses.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] ID_rs1;
    logic [REG_W-1:0] ID_rs2;
    logic             ID_re1;
    logic             ID_re2;
    logic [REG_W-1:0] EX_rd;
    logic             EX_rf_we;
    logic             EX_is_load;
    logic [REG_W-1:0] EX_rs1;
    logic [REG_W-1:0] EX_rs2;
    logic [REG_W-1:0] MEM_rd;
    logic [REG_W-1:0] WB_rd;
    logic             MEM_rf_we;
    logic             WB_rf_we;
    logic             EX_branch_taken;
    logic             MEM_mem_req;
    logic             mem_ack;

    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             ex_mem_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_abort;
    logic             mem_err;

    modport master (
        output ID_rs1, ID_rs2, ID_re1, ID_re2, EX_rd, EX_rf_we, EX_is_load,
               EX_rs1, EX_rs2, MEM_rd, WB_rd, MEM_rf_we, WB_rf_we,
               EX_branch_taken, MEM_mem_req, mem_ack,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_wb_bubble, fwd_a, fwd_b,
               mem_abort, mem_err
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_re1, ID_re2, EX_rd, EX_rf_we, EX_is_load,
               EX_rs1, EX_rs2, MEM_rd, WB_rd, MEM_rf_we, WB_rf_we,
               EX_branch_taken, MEM_mem_req, mem_ack,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_wb_bubble, fwd_a, fwd_b,
               mem_abort, mem_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational forwarding selector for one EX operand.
//   src            - source register of the EX instruction
//   mem_rd, mem_we - destination/write enable of the instruction in MEM
//   wb_rd, wb_we   - destination/write enable of the instruction in WB
//   sel            - FWD_RF / FWD_MEM / FWD_WB
// The MEM stage holds the younger result, so it wins over WB.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_we,
    output logic [1:0]       sel
);

    // Operand source selection, MEM before WB before register file.
    always_comb begin
        sel = FWD_RF;
        if (fwd_hit(mem_we, mem_rd, src)) begin
            sel = FWD_MEM;
        end else if (fwd_hit(wb_we, wb_rd, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/sequencing control for the 5-stage pipeline.
//   clk, rst      - clock, asynchronous active-high reset
//   hz (slave)    - stage information in, stall/flush/bubble/forward controls out
//   stall_cycles  - saturating count of cycles with pc_stall set
//   flush_count   - saturating count of cycles with if_id_flush set
// Priority of the stage controls: memory wait > taken branch > load-use > none.
// The memory wait FSM times out after MEM_TIMEOUT cycles; in the timeout cycle
// the stall is released and mem_abort/mem_err pulse together.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    mem_state_e        state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic              timeout_now_s;
    logic              mem_busy_s;
    logic              load_use_s;
    logic              stall_inc_s;
    logic              flush_inc_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    pipe_hazard_ctrl_fwd_unit u_fwd_a (
        .src    (hz.EX_rs1),
        .mem_rd (hz.MEM_rd),
        .mem_we (hz.MEM_rf_we),
        .wb_rd  (hz.WB_rd),
        .wb_we  (hz.WB_rf_we),
        .sel    (fwd_a_s)
    );

    pipe_hazard_ctrl_fwd_unit u_fwd_b (
        .src    (hz.EX_rs2),
        .mem_rd (hz.MEM_rd),
        .mem_we (hz.MEM_rf_we),
        .wb_rd  (hz.WB_rd),
        .wb_we  (hz.WB_rf_we),
        .sel    (fwd_b_s)
    );

    // Hazard detection terms.
    always_comb begin
        // An ack coinciding with the timeout count is a normal completion.
        timeout_now_s = (state_r == MEM_WAIT) && (wait_cnt_r == TIMEOUT_C) && !hz.mem_ack;
        mem_busy_s    = hz.MEM_mem_req && !hz.mem_ack && !timeout_now_s;
        load_use_s    = hz.EX_is_load && hz.EX_rf_we && (hz.EX_rd != {REG_W{1'b0}}) &&
                        ((hz.ID_re1 && (hz.ID_rs1 == hz.EX_rd)) ||
                         (hz.ID_re2 && (hz.ID_rs2 == hz.EX_rd)));
        stall_inc_s   = mem_busy_s || (!hz.EX_branch_taken && load_use_s);
        flush_inc_s   = !mem_busy_s && hz.EX_branch_taken;
    end

    // Stage control outputs in priority order.
    always_comb begin
        hz.pc_stall      = 1'b0;
        hz.if_id_stall   = 1'b0;
        hz.id_ex_stall   = 1'b0;
        hz.ex_mem_stall  = 1'b0;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_flush   = 1'b0;
        hz.mem_wb_bubble = 1'b0;
        hz.fwd_a         = fwd_a_s;
        hz.fwd_b         = fwd_b_s;
        hz.mem_abort     = timeout_now_s;
        hz.mem_err       = timeout_now_s;
        if (mem_busy_s) begin
            // Freeze everything up to EX/MEM; a pending branch stays in EX
            // and is flushed once the access completes.
            hz.pc_stall      = 1'b1;
            hz.if_id_stall   = 1'b1;
            hz.id_ex_stall   = 1'b1;
            hz.ex_mem_stall  = 1'b1;
            hz.mem_wb_bubble = 1'b1;
        end else if (hz.EX_branch_taken) begin
            hz.if_id_flush   = 1'b1;
            hz.id_ex_flush   = 1'b1;
        end else if (load_use_s) begin
            // One-cycle bubble; next cycle the load sits in MEM and WB forward covers it.
            hz.pc_stall      = 1'b1;
            hz.if_id_stall   = 1'b1;
            hz.id_ex_flush   = 1'b1;
        end else begin
            hz.pc_stall      = 1'b0;
        end
    end

    // Data-memory wait FSM with timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= MEM_IDLE;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                MEM_IDLE: begin
                    if (hz.MEM_mem_req && !hz.mem_ack) begin
                        state_r    <= MEM_WAIT;
                        wait_cnt_r <= WAIT_W'(1);
                    end else begin
                        state_r    <= MEM_IDLE;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end
                end
                MEM_WAIT: begin
                    if (hz.mem_ack || timeout_now_s) begin
                        state_r    <= MEM_IDLE;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else begin
                        state_r    <= MEM_WAIT;
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                default: begin
                    state_r    <= MEM_IDLE;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating stall/flush performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing block for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Decides per cycle which pipeline registers hold, which take a bubble, and which forwarding source feeds each EX operand.
- Owns the multi-cycle data-memory wait FSM with timeout, and keeps stall/flush performance counters.
- Sits beside the datapath; stall/flush outputs drive the enable and clear inputs of each stage register.

Parameters:
- MEM_TIMEOUT, 255, maximum wait cycles for mem_ack before the access is aborted (1..1023).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID
- ID_re1, ID_re2  in  1 each  source register actually read
- EX_rd  in  5  destination register in EX
- EX_rf_we  in  1  EX writes the register file
- EX_is_load  in  1  EX instruction is a load
- EX_rs1, EX_rs2  in  5 each  source registers of the EX instruction (forwarding)
- MEM_rd, WB_rd  in  5 each  destination registers in MEM and WB
- MEM_rf_we, WB_rf_we  in  1 each  register-file write enables in MEM and WB
- EX_branch_taken  in  1  branch or jump resolved taken in EX
- MEM_mem_req  in  1  MEM stage holds an access awaiting memory
- mem_ack  in  1  single-cycle completion pulse from data memory
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the register
- if_id_flush, id_ex_flush  out  1 each  load a bubble (have_inst=0, rf_we=0, inst=0)
- mem_wb_bubble  out  1  MEM/WB captures a bubble
- fwd_a, fwd_b  out  2 each  EX operand source: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB writeback data
- mem_abort, mem_err  out  1 each  single-cycle pulses on timeout
- stall_cycles, flush_count  out  CNT_W each  performance counters

Behaviour:
- **Reset.** All registered state is cleared: FSM goes to IDLE, wait counter = 0, counters = 0, mem_abort = mem_err = 0. The combinational outputs then evaluate from the inputs with FSM = IDLE.
- **Forwarding (combinational).**
  - A source of 0 is never forwarded.
  - A MEM hit (MEM_rf_we and MEM_rd == src) takes priority over a WB hit.
  - Otherwise the source is the register file.
- **Memory wait.**
  - mem_busy = MEM_mem_req & ~mem_ack & ~timeout_now.
  - While mem_busy: pc, IF/ID, ID/EX and EX/MEM all stall, and mem_wb_bubble = 1.
  - mem_busy overrides every other condition, and no flush is issued during it.
- **Memory FSM.**
  - States are IDLE and WAIT.
  - IDLE → WAIT when MEM_mem_req & ~mem_ack; the wait counter is set to 1.
  - WAIT increments the counter each cycle.
  - WAIT → IDLE on mem_ack.
  - timeout_now = WAIT & (counter == MEM_TIMEOUT) & ~mem_ack. In that cycle the stall is released, mem_abort and mem_err pulse, and the FSM returns to IDLE.
  - If mem_ack arrives in the same cycle as the timeout, the ack wins and there is no error.
  - A new MEM_mem_req in the cycle immediately after completion starts a fresh wait.
- **Branch flush** (when not mem_busy): EX_branch_taken sets if_id_flush = id_ex_flush = 1 and issues no stall. The flush is deferred while mem_busy, because EX is frozen and the branch signal persists.
- **Load-use** (when not mem_busy and not branch taken):
  - Condition: EX_is_load & EX_rf_we & EX_rd ≠ 0 & ((ID_re1 & ID_rs1 == EX_rd) | (ID_re2 & ID_rs2 == EX_rd)).
  - Response: stall pc and IF/ID, and set id_ex_flush for exactly one cycle. The next cycle the load is in MEM, and the WB forward covers the dependency.
- **Priority:** mem_busy > branch flush > load-use > normal.
- **Counters.**
  - stall_cycles increments in every cycle where pc_stall = 1.
  - flush_count increments in every cycle where if_id_flush = 1.
  - Both saturate at all-ones.
- **Reset mid-wait** clears the FSM immediately, with no abort pulse.

Decomposition:
- Shared package defines:
  - FWD_RF, FWD_MEM, FWD_WB encodings (2-bit)
  - FSM state encodings MEM_IDLE and MEM_WAIT
  - the register-index width of 5
- One natural sub-module, fwd_unit: a combinational forwarding selector instantiated once per operand.

Test Plan:
- **Forward priority:** EX_rs1=5, MEM_rd=5/we=1, WB_rd=5/we=1 → fwd_a=1. Set MEM_rf_we=0 → fwd_a=2. Set rs1=0 → fwd_a=0.
- **Load-use:** EX_is_load=1, EX_rd=7, ID_rs2=7, ID_re2=1 → for one cycle pc_stall = if_id_stall = id_ex_flush = 1. The following cycle shows no stall; stall_cycles=1.
- **Branch vs load-use:** both conditions true in the same cycle → if_id_flush = id_ex_flush = 1 and pc_stall = 0; flush_count=1.
- **Memory wait:** MEM_mem_req=1 with mem_ack after 3 cycles → ex_mem_stall and mem_wb_bubble are high for exactly 3 cycles, and both drop in the ack cycle. A branch held throughout flushes only in the ack cycle.
- **Timeout:** MEM_TIMEOUT=4 and no ack → stall is high for 4 cycles (the initial IDLE cycle plus WAIT counts 1–3). mem_err and mem_abort pulse in the 5th cycle with the stall released. With ack coincident at count 4 → no error.
- **Async reset during WAIT:** all stalls clear and the counters read 0 with no clock edge; mem_err stays 0.
